// File: rtl/wb_exmem_prefetch.sv
// Single-line read buffer in front of a slow Wishbone BRAM slave.
// Read hits are served in one cycle; misses fetch the aligned line; writes go straight through.
module wb_exmem_prefetch #(
    parameter int          LINE_WORDS = 4,
    parameter logic [7:0]  BASE_HI    = 8'h38,
    parameter int          CNT_W      = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    output logic             mem_cyc_o,
    output logic             mem_stb_o,
    output logic             mem_we_o,
    output logic [3:0]       mem_sel_o,
    output logic [31:0]      mem_adr_o,
    output logic [31:0]      mem_dat_o,
    input  logic [31:0]      mem_dat_i,
    input  logic             mem_ack_i,
    input  logic             flush_i,
    output logic [CNT_W-1:0] hit_cnt_o,
    output logic [CNT_W-1:0] miss_cnt_o
);

    localparam int IW = $clog2(LINE_WORDS);
    localparam int TW = 22 - IW;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;
    localparam logic [1:0] S_WRITE = 2'd3;

    logic [1:0]    state;
    logic [31:0]   line_buf [LINE_WORDS];
    logic          line_vld;
    logic [TW-1:0] line_tag;
    logic          flush_pend;
    logic [IW-1:0] fill_idx;
    logic [IW-1:0] req_idx;

    logic          req;
    logic [TW-1:0] req_tag;
    logic [IW-1:0] req_w;
    logic          hit;
    logic [TW-1:0] wr_tag;
    logic [IW-1:0] wr_w;

    // A request still visible while its ack is high is the old one being retired.
    assign req     = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:24] == BASE_HI) & ~wbs_ack_o;
    assign req_tag = wbs_adr_i[23:2+IW];
    assign req_w   = wbs_adr_i[1+IW:2];
    assign hit     = line_vld && (line_tag == req_tag);
    assign wr_tag  = mem_adr_o[23:2+IW];
    assign wr_w    = mem_adr_o[1+IW:2];

    assign mem_stb_o = mem_cyc_o;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= S_IDLE;
            line_vld   <= 1'b0;
            line_tag   <= '0;
            flush_pend <= 1'b0;
            fill_idx   <= '0;
            req_idx    <= '0;
            wbs_ack_o  <= 1'b0;
            wbs_dat_o  <= '0;
            mem_cyc_o  <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_sel_o  <= '0;
            mem_adr_o  <= '0;
            mem_dat_o  <= '0;
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
            for (int i = 0; i < LINE_WORDS; i++) line_buf[i] <= '0;
        end else begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            case (state)
                S_IDLE: begin
                    if (flush_i) line_vld <= 1'b0;
                    if (req) begin
                        req_idx    <= req_w;
                        flush_pend <= 1'b0;
                        if (wbs_we_i) begin
                            state     <= S_WRITE;
                            mem_cyc_o <= 1'b1;
                            mem_we_o  <= 1'b1;
                            mem_sel_o <= wbs_sel_i;
                            mem_adr_o <= wbs_adr_i;
                            mem_dat_o <= wbs_dat_i;
                        end else if (hit) begin
                            wbs_ack_o <= 1'b1;
                            wbs_dat_o <= line_buf[req_w];
                            if (hit_cnt_o != '1) hit_cnt_o <= hit_cnt_o + CNT_W'(1);
                        end else begin
                            if (miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + CNT_W'(1);
                            line_vld  <= 1'b0;
                            line_tag  <= req_tag;
                            fill_idx  <= '0;
                            state     <= S_FILL;
                            mem_cyc_o <= 1'b1;
                            mem_we_o  <= 1'b0;
                            mem_sel_o <= 4'hF;
                            mem_adr_o <= {BASE_HI, req_tag, {IW{1'b0}}, 2'b00};
                        end
                    end
                end
                S_FILL: begin
                    if (flush_i) flush_pend <= 1'b1;
                    if (mem_cyc_o) begin
                        if (mem_ack_i) begin
                            // Drop the strobe for one cycle between beats.
                            line_buf[fill_idx] <= mem_dat_i;
                            mem_cyc_o <= 1'b0;
                            mem_sel_o <= '0;
                            mem_adr_o <= '0;
                            if (fill_idx == IW'(LINE_WORDS - 1)) begin
                                line_vld <= ~(flush_pend | flush_i);
                                state    <= S_RESP;
                            end else begin
                                fill_idx <= fill_idx + IW'(1);
                            end
                        end
                    end else begin
                        mem_cyc_o <= 1'b1;
                        mem_sel_o <= 4'hF;
                        mem_adr_o <= {BASE_HI, line_tag, fill_idx, 2'b00};
                    end
                end
                S_RESP: begin
                    if (flush_i) line_vld <= 1'b0;
                    wbs_ack_o <= 1'b1;
                    wbs_dat_o <= line_buf[req_idx];
                    state     <= S_IDLE;
                end
                S_WRITE: begin
                    if (flush_i) flush_pend <= 1'b1;
                    if (mem_ack_i) begin
                        // Keep the buffered copy coherent with what the slave now holds.
                        if (flush_pend | flush_i) begin
                            line_vld <= 1'b0;
                        end else if (line_vld && line_tag == wr_tag) begin
                            for (int b = 0; b < 4; b++)
                                if (mem_sel_o[b]) line_buf[wr_w][8*b +: 8] <= mem_dat_o[8*b +: 8];
                        end
                        mem_cyc_o <= 1'b0;
                        mem_we_o  <= 1'b0;
                        mem_sel_o <= '0;
                        mem_adr_o <= '0;
                        mem_dat_o <= '0;
                        wbs_ack_o <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_exmem_prefetch.sv
// Directed + random bench for wb_exmem_prefetch against a word-array reference model.
module tb_wb_exmem_prefetch;

    localparam int CW   = 3;
    localparam int CMAX = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stb = 1'b0, cyc = 1'b0, we = 1'b0, flush = 1'b0;
    logic [3:0]    sel = '0;
    logic [31:0]   adr = '0, wdat = '0;
    logic          wbs_ack;
    logic [31:0]   wbs_dat;
    logic          mem_cyc, mem_stb, mem_we;
    logic [3:0]    mem_sel;
    logic [31:0]   mem_adr, mem_dat_o;
    logic [31:0]   mem_dat_i = '0;
    logic          mem_ack = 1'b0;
    logic [CW-1:0] hit_cnt, miss_cnt;

    always #5 clk = ~clk;

    wb_exmem_prefetch #(.LINE_WORDS(4), .BASE_HI(8'h38), .CNT_W(CW)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(wbs_ack), .wbs_dat_o(wbs_dat),
        .mem_cyc_o(mem_cyc), .mem_stb_o(mem_stb), .mem_we_o(mem_we), .mem_sel_o(mem_sel),
        .mem_adr_o(mem_adr), .mem_dat_o(mem_dat_o), .mem_dat_i(mem_dat_i), .mem_ack_i(mem_ack),
        .flush_i(flush), .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
    );

    // Slave: acks after `lat` cycles of strobe, logs every transaction.
    logic [31:0] smem [16];
    int          lat = 1;
    int          scnt = 0;
    logic [31:0] rd_q [$];
    int          wr_n = 0;
    logic [31:0] wr_adr, wr_dat;
    logic [3:0]  wr_sel;
    int          cyc_edges = 0;
    int          zero_viol = 0;

    always @(posedge clk) begin
        mem_ack <= 1'b0;
        if (mem_cyc) cyc_edges <= cyc_edges + 1;
        if (!mem_cyc) scnt <= 0;
        else if (mem_stb && !mem_ack) begin
            if (scnt >= lat - 1) begin
                mem_ack <= 1'b1;
                scnt    <= 0;
                if (mem_we) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_sel[b]) smem[mem_adr[5:2]][8*b +: 8] <= mem_dat_o[8*b +: 8];
                    wr_n   <= wr_n + 1;
                    wr_adr <= mem_adr;
                    wr_dat <= mem_dat_o;
                    wr_sel <= mem_sel;
                end else begin
                    mem_dat_i <= smem[mem_adr[5:2]];
                    rd_q.push_back(mem_adr);
                end
            end else scnt <= scnt + 1;
        end
    end

    always @(negedge clk)
        if ((mem_stb !== mem_cyc) ||
            (!mem_cyc && (mem_we || mem_sel != 0 || mem_adr != 0 || mem_dat_o != 0)))
            zero_viol = zero_viol + 1;

    // Reference model: memory contents plus which line the buffer should hold.
    logic [31:0] ref_mem [16];
    bit          ref_valid = 0;
    logic [19:0] ref_tag = '0;
    int          ref_hit = 0, ref_miss = 0;
    int          checks = 0, errors = 0;

    function automatic int sat(input int x);
        return (x > CMAX) ? CMAX : x;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_hit"},  32'(hit_cnt),  32'(sat(ref_hit)));
        chk({tag, "_miss"}, 32'(miss_cnt), 32'(sat(ref_miss)));
    endtask

    task automatic do_read(input logic [31:0] a, input bit fl);
        bit          exp_hit;
        bit          got;
        int          n;
        logic [31:0] d;
        exp_hit = ref_valid && (ref_tag == a[23:4]);
        rd_q.delete();
        got = 0; n = 0;
        adr = a; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
        while (n < 400) begin
            @(posedge clk); #1;
            n++;
            flush = fl && (n == 3);
            if (wbs_ack) begin got = 1; break; end
        end
        flush = 1'b0;
        d = wbs_dat;
        stb = 1'b0; cyc = 1'b0;
        chk("rd_ack", 32'(got), 32'd1);
        chk("rd_dat", d, ref_mem[a[5:2]]);
        if (exp_hit) begin
            ref_hit++;
            chk("hit_lat", 32'(n), 32'd1);
            chk("hit_nomem", 32'(rd_q.size()), 32'd0);
        end else begin
            ref_miss++;
            chk("miss_beats", 32'(rd_q.size()), 32'd4);
            for (int k = 0; k < rd_q.size(); k++)
                chk("miss_adr", rd_q[k], {a[31:4], 4'(k * 4)});
            ref_valid = !fl;
            ref_tag   = a[23:4];
        end
        chk_cnt("rd");
        idle_cycle();
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int          n;
        bit          got;
        int          wn0;
        logic [31:0] rd;
        wn0 = wr_n;
        rd_q.delete();
        got = 0; n = 0;
        adr = a; wdat = d; sel = s; we = 1'b1; stb = 1'b1; cyc = 1'b1;
        while (n < 400) begin
            @(posedge clk); #1;
            n++;
            if (wbs_ack) begin got = 1; break; end
        end
        rd = wbs_dat;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        for (int b = 0; b < 4; b++)
            if (s[b]) ref_mem[a[5:2]][8*b +: 8] = d[8*b +: 8];
        chk("wr_ack", 32'(got), 32'd1);
        chk("wr_rdat", rd, 32'd0);
        chk("wr_count", 32'(wr_n - wn0), 32'd1);
        chk("wr_adr", wr_adr, a);
        chk("wr_dat", wr_dat, d);
        chk("wr_sel", 32'(wr_sel), 32'(s));
        chk("wr_noread", 32'(rd_q.size()), 32'd0);
        chk_cnt("wr");
        idle_cycle();
    endtask

    initial begin
        int          acks;
        int          ce0;
        int          op;
        logic [31:0] a;
        logic [31:0] d;

        for (int i = 0; i < 16; i++) begin
            smem[i]    = 32'hC0DE_0000 + 32'(i * 32'h0101);
            ref_mem[i] = 32'hC0DE_0000 + 32'(i * 32'h0101);
        end
        smem[1]    = 32'hAAAA_AAAA;
        ref_mem[1] = 32'hAAAA_AAAA;

        repeat (3) idle_cycle();
        chk("rst_ack", 32'(wbs_ack), 32'd0);
        chk("rst_dat", wbs_dat, 32'd0);
        chk("rst_cyc", 32'(mem_cyc), 32'd0);
        chk("rst_adr", mem_adr, 32'd0);
        chk_cnt("rst");
        rst = 1'b0;
        idle_cycle();

        // Miss, then two hits in the same line.
        lat = 11;
        do_read(32'h3800_0008, 1'b0);
        chk("first_miss", 32'(miss_cnt), 32'd1);
        do_read(32'h3800_000C, 1'b0);
        do_read(32'h3800_0000, 1'b0);
        chk("two_hits", 32'(hit_cnt), 32'd2);

        // Partial write into the buffered line, then read it back.
        lat = 3;
        do_write(32'h3800_0004, 32'h1234_5678, 4'b0011);
        do_read(32'h3800_0004, 1'b0);
        chk("merge_val", ref_mem[1], 32'hAAAA_5678);

        // Flush during a fill: that read completes, the line is not kept.
        do_read(32'h3800_0010, 1'b1);
        do_read(32'h3800_0014, 1'b0);

        // Reset in the middle of a fill.
        lat = 5;
        adr = 32'h3800_0020; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
        repeat (3) idle_cycle();
        rst = 1'b1;
        idle_cycle();
        chk("rstfill_cyc", 32'(mem_cyc), 32'd0);
        chk("rstfill_hit", 32'(hit_cnt), 32'd0);
        chk("rstfill_miss", 32'(miss_cnt), 32'd0);
        rst = 1'b0; stb = 1'b0; cyc = 1'b0;
        ref_valid = 0; ref_hit = 0; ref_miss = 0;
        idle_cycle();
        do_read(32'h3800_0020, 1'b0);
        chk("post_rst_miss", 32'(miss_cnt), 32'd1);

        // Foreign address is ignored entirely.
        ce0 = cyc_edges; acks = 0;
        adr = 32'h3000_0000; we = 1'b0; stb = 1'b1; cyc = 1'b1;
        repeat (50) begin
            idle_cycle();
            if (wbs_ack) acks++;
        end
        stb = 1'b0; cyc = 1'b0;
        idle_cycle();
        chk("foreign_ack", 32'(acks), 32'd0);
        chk("foreign_mem", 32'(cyc_edges - ce0), 32'd0);
        chk_cnt("foreign");

        // Random mix; CNT_W=3 makes the counters saturate along the way.
        for (int i = 0; i < 60; i++) begin
            lat = $urandom_range(1, 4);
            op  = $urandom_range(0, 9);
            a   = 32'h3800_0000 | (32'($urandom_range(0, 15)) << 2);
            if (op < 6) begin
                do_read(a, $urandom_range(0, 7) == 0);
            end else if (op < 9) begin
                d = $urandom;
                do_write(a, d, 4'($urandom_range(1, 15)));
            end else begin
                flush = 1'b1;
                idle_cycle();
                flush = 1'b0;
                ref_valid = 0;
                idle_cycle();
            end
        end

        chk("mem_idle_zero", 32'(zero_viol), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
